id_stage_fwd: RTL and testbench

- Parametrised successor to the 16-bit instruction-decode stage.
- Decodes the 16-bit instruction word (opcode at [15:11]) into EX operands reg_A, reg_B and the store data smdr, and registers the instruction into ex_ir.
- Adds, relative to the current decode stage:
  - operand forwarding from EX and MEM write-backs;
  - load-use interlock with bubble insertion;
  - branch flush;
  - a saturating bubble counter.
- Operand width and register count are generic.

---
 rtl/id_stage_fwd_if.sv | 38 +++
 rtl/id_stage_fwd.sv | 159 +++++++++++++++
 tb/tb_id_stage_fwd.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/id_stage_fwd_if.sv
// Bundles the decode-stage inputs (instruction, register file, forwarding paths) and its EX-facing outputs.
interface id_stage_fwd_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
);
  logic                         en;
  logic                         flush;
  logic [15:0]                  id_iri;
  logic [NUM_REGS*DATA_W-1:0]   gr_flat;
  logic                         fwd_ex_en;
  logic [2:0]                   fwd_ex_addr;
  logic [DATA_W-1:0]            fwd_ex_data;
  logic                         fwd_mem_en;
  logic [2:0]                   fwd_mem_addr;
  logic [DATA_W-1:0]            fwd_mem_data;
  logic [15:0]                  id_iro;
  logic                         stall;
  logic [15:0]                  ex_ir;
  logic [DATA_W-1:0]            reg_A;
  logic [DATA_W-1:0]            reg_B;
  logic [DATA_W-1:0]            smdr;
  logic [CNT_W-1:0]             bubble_cnt;

  modport master (
    output en, flush, id_iri, gr_flat,
    output fwd_ex_en, fwd_ex_addr, fwd_ex_data,
    output fwd_mem_en, fwd_mem_addr, fwd_mem_data,
    input  id_iro, stall, ex_ir, reg_A, reg_B, smdr, bubble_cnt
  );

  modport slave (
    input  en, flush, id_iri, gr_flat,
    input  fwd_ex_en, fwd_ex_addr, fwd_ex_data,
    input  fwd_mem_en, fwd_mem_addr, fwd_mem_data,
    output id_iro, stall, ex_ir, reg_A, reg_B, smdr, bubble_cnt
  );
endinterface

// File: rtl/id_stage_fwd.sv
// Instruction decode with EX/MEM forwarding, load-use bubble, branch flush and saturating bubble counter.
// Latency 1 cycle id_iri -> ex_ir/operands; stall is combinational and en=0 holds every register.
module id_stage_fwd #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
) (
  input logic          clock,
  input logic          reset,
  id_stage_fwd_if.slave io
);
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  logic [15:0]       ex_ir_q;
  logic [DATA_W-1:0] reg_a_q, reg_b_q, smdr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [4:0]        op;
  logic [2:0]        r1, r2, r3;
  logic [DATA_W-1:0] s1, s2, s3;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic              rd1, rd2, rd3, is_store, hazard;

  assign op = io.id_iri[15:11];
  assign r1 = io.id_iri[10:8];
  assign r2 = io.id_iri[6:4];
  assign r3 = io.id_iri[2:0];

  // EX result is youngest, so it beats MEM; register indices beyond the file read zero.
  function automatic logic [DATA_W-1:0] src_sel(
    input logic [2:0]                 n,
    input logic                       ex_en,
    input logic [2:0]                 ex_addr,
    input logic [DATA_W-1:0]          ex_data,
    input logic                       mem_en,
    input logic [2:0]                 mem_addr,
    input logic [DATA_W-1:0]          mem_data,
    input logic [NUM_REGS*DATA_W-1:0] gr
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (ex_en && ex_addr == n) begin
      v = ex_data;
    end else if (mem_en && mem_addr == n) begin
      v = mem_data;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(n) == i) v = gr[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  assign s1 = src_sel(r1, io.fwd_ex_en, io.fwd_ex_addr, io.fwd_ex_data,
                      io.fwd_mem_en, io.fwd_mem_addr, io.fwd_mem_data, io.gr_flat);
  assign s2 = src_sel(r2, io.fwd_ex_en, io.fwd_ex_addr, io.fwd_ex_data,
                      io.fwd_mem_en, io.fwd_mem_addr, io.fwd_mem_data, io.gr_flat);
  assign s3 = src_sel(r3, io.fwd_ex_en, io.fwd_ex_addr, io.fwd_ex_data,
                      io.fwd_mem_en, io.fwd_mem_addr, io.fwd_mem_data, io.gr_flat);

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    rd1      = 1'b0;
    rd2      = 1'b0;
    rd3      = 1'b0;
    is_store = 1'b0;
    case (op)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI: begin
        rd1   = 1'b1;
        dec_a = s1;
        dec_b = DATA_W'(io.id_iri[7:0]);
      end
      OP_LDIH: begin
        rd1   = 1'b1;
        dec_a = s1;
        dec_b = DATA_W'({io.id_iri[7:0], 8'h00});
      end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        rd2   = 1'b1;
        rd3   = 1'b1;
        dec_a = s2;
        dec_b = s3;
      end
      OP_LOAD, OP_STORE, OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
        rd2   = 1'b1;
        dec_a = s2;
        dec_b = DATA_W'(io.id_iri[3:0]);
        if (op == OP_STORE) begin
          rd1      = 1'b1;
          is_store = 1'b1;
        end
      end
      OP_NOP, OP_HALT, OP_JUMP: ;
      default: ;
    endcase
  end

  assign hazard = (ex_ir_q[15:11] == OP_LOAD) &&
                  ((rd1 && r1 == ex_ir_q[10:8]) ||
                   (rd2 && r2 == ex_ir_q[10:8]) ||
                   (rd3 && r3 == ex_ir_q[10:8]));

  assign io.stall      = hazard && !io.flush;
  assign io.id_iro     = io.id_iri;
  assign io.ex_ir      = ex_ir_q;
  assign io.reg_A      = reg_a_q;
  assign io.reg_B      = reg_b_q;
  assign io.smdr       = smdr_q;
  assign io.bubble_cnt = cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ir_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      smdr_q  <= '0;
      cnt_q   <= '0;
    end else if (io.en) begin
      if (io.flush || io.stall) begin
        ex_ir_q <= '0;
        reg_a_q <= '0;
        reg_b_q <= '0;
        if (io.stall && ~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        ex_ir_q <= (op == OP_JUMP) ? 16'h0000 : io.id_iri;
        reg_a_q <= dec_a;
        reg_b_q <= dec_b;
        if (is_store) smdr_q <= s1;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: expected stage outputs are queued when an instruction is driven and checked after the edge.
module tb_id_stage_fwd;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  id_stage_fwd_if #(.DATA_W(16), .NUM_REGS(8), .CNT_W(16)) ifa ();
  id_stage_fwd_if #(.DATA_W(16), .NUM_REGS(8), .CNT_W(2))  ifb ();

  id_stage_fwd #(.DATA_W(16), .NUM_REGS(8), .CNT_W(16)) u_dut (.clock(clock), .reset(reset), .io(ifa));
  id_stage_fwd #(.DATA_W(16), .NUM_REGS(8), .CNT_W(2))  u_sat (.clock(clock), .reset(reset), .io(ifb));

  // Saturation instance follows the same stimulus.
  assign ifb.en           = ifa.en;
  assign ifb.flush        = ifa.flush;
  assign ifb.id_iri       = ifa.id_iri;
  assign ifb.gr_flat      = ifa.gr_flat;
  assign ifb.fwd_ex_en    = ifa.fwd_ex_en;
  assign ifb.fwd_ex_addr  = ifa.fwd_ex_addr;
  assign ifb.fwd_ex_data  = ifa.fwd_ex_data;
  assign ifb.fwd_mem_en   = ifa.fwd_mem_en;
  assign ifb.fwd_mem_addr = ifa.fwd_mem_addr;
  assign ifb.fwd_mem_data = ifa.fwd_mem_data;

  localparam logic [4:0] ADD = 5'b01000, SUB = 5'b01010, ADDI = 5'b01001, LDIH = 5'b10000;
  localparam logic [4:0] LOAD = 5'b00010, STORE = 5'b00011, JUMP = 5'b11000;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [15:0] ir, a, b, s, cnt;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [15:0] rtype(input logic [4:0] op, input logic [2:0] a, b, c);
    return {op, a, 1'b0, b, 1'b0, c};
  endfunction
  function automatic logic [15:0] stype(input logic [4:0] op, input logic [2:0] a, b, input logic [3:0] imm);
    return {op, a, 1'b0, b, imm};
  endfunction
  function automatic logic [15:0] itype(input logic [4:0] op, input logic [2:0] a, input logic [7:0] imm);
    return {op, a, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk({tag, ".stall"}, 32'(ifa.stall), 32'(exp));
  endtask

  task automatic step(input string tag, input logic [15:0] ir, a, b, s, cnt);
    exp_t e;
    e.tag = tag; e.ir = ir; e.a = a; e.b = b; e.s = s; e.cnt = cnt;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".ex_ir"}, 32'(ifa.ex_ir), 32'(e.ir));
    chk({e.tag, ".reg_A"}, 32'(ifa.reg_A), 32'(e.a));
    chk({e.tag, ".reg_B"}, 32'(ifa.reg_B), 32'(e.b));
    chk({e.tag, ".smdr"}, 32'(ifa.smdr), 32'(e.s));
    chk({e.tag, ".bubble_cnt"}, 32'(ifa.bubble_cnt), 32'(e.cnt));
  endtask

  task automatic no_fwd();
    ifa.fwd_ex_en = 1'b0; ifa.fwd_ex_addr = 3'd0; ifa.fwd_ex_data = 16'h0;
    ifa.fwd_mem_en = 1'b0; ifa.fwd_mem_addr = 3'd0; ifa.fwd_mem_data = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] add123, add143, ld4;
    add123 = rtype(ADD, 3'd1, 3'd2, 3'd3);
    add143 = rtype(ADD, 3'd1, 3'd4, 3'd3);
    ld4    = stype(LOAD, 3'd4, 3'd2, 4'd0);

    // gr0..7 = 0, 0x11, 5, 7, 0x44, 0x55, 0x66, 0x77
    ifa.gr_flat = {16'h0077, 16'h0066, 16'h0055, 16'h0044, 16'h0007, 16'h0005, 16'h0011, 16'h0000};
    no_fwd();
    reset = 1'b1; ifa.en = 1'b0; ifa.flush = 1'b0; ifa.id_iri = add123;
    step("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    reset = 1'b0; ifa.en = 1'b1;
    chk_stall("add_rf", 1'b0);
    chk("id_iro", 32'(ifa.id_iro), 32'(add123));
    step("add_rf", add123, 16'h0005, 16'h0007, 16'h0, 16'h0);

    ifa.id_iri = itype(LDIH, 3'd1, 8'hAB);
    step("ldih", itype(LDIH, 3'd1, 8'hAB), 16'h0011, 16'hAB00, 16'h0, 16'h0);

    ifa.id_iri = stype(STORE, 3'd5, 3'd2, 4'd3);
    step("store", stype(STORE, 3'd5, 3'd2, 4'd3), 16'h0005, 16'h0003, 16'h0055, 16'h0);

    ifa.id_iri = itype(ADDI, 3'd1, 8'h3C);
    step("addi", itype(ADDI, 3'd1, 8'h3C), 16'h0011, 16'h003C, 16'h0055, 16'h0);

    ifa.fwd_ex_en = 1'b1; ifa.fwd_ex_addr = 3'd2; ifa.fwd_ex_data = 16'h1111;
    ifa.fwd_mem_en = 1'b1; ifa.fwd_mem_addr = 3'd2; ifa.fwd_mem_data = 16'h2222;
    ifa.id_iri = rtype(SUB, 3'd1, 3'd2, 3'd3);
    step("fwd_both", rtype(SUB, 3'd1, 3'd2, 3'd3), 16'h1111, 16'h0007, 16'h0055, 16'h0);

    ifa.fwd_ex_en = 1'b0;
    step("fwd_mem", rtype(SUB, 3'd1, 3'd2, 3'd3), 16'h2222, 16'h0007, 16'h0055, 16'h0);

    no_fwd();
    ifa.id_iri = itype(JUMP, 3'd0, 8'h05);
    step("jump", 16'h0, 16'h0, 16'h0, 16'h0055, 16'h0);

    ifa.id_iri = ld4;
    step("load", ld4, 16'h0005, 16'h0, 16'h0055, 16'h0);

    ifa.id_iri = add143;
    chk_stall("ldu", 1'b1);
    step("ldu_bubble", 16'h0, 16'h0, 16'h0, 16'h0055, 16'h1);

    ifa.fwd_mem_en = 1'b1; ifa.fwd_mem_addr = 3'd4; ifa.fwd_mem_data = 16'h00FF;
    chk_stall("ldu_release", 1'b0);
    step("ldu_reissue", add143, 16'h00FF, 16'h0007, 16'h0055, 16'h1);

    no_fwd();
    ifa.id_iri = ld4;
    step("load2", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);
    ifa.id_iri = add123;
    chk_stall("no_r4_read", 1'b0);
    step("no_r4_read", add123, 16'h0005, 16'h0007, 16'h0055, 16'h1);

    ifa.id_iri = ld4;
    step("load3", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);
    ifa.id_iri = add143; ifa.flush = 1'b1;
    chk_stall("flush_hazard", 1'b0);
    step("flush", 16'h0, 16'h0, 16'h0, 16'h0055, 16'h1);
    ifa.flush = 1'b0;

    ifa.id_iri = ld4;
    step("load4", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);
    ifa.en = 1'b0;
    ifa.id_iri = add143;
    chk_stall("en0_stall", 1'b1);
    step("hold1", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);
    ifa.id_iri = itype(LDIH, 3'd3, 8'h12);
    step("hold2", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);
    ifa.id_iri = stype(STORE, 3'd6, 3'd1, 4'd2);
    step("hold3", ld4, 16'h0005, 16'h0, 16'h0055, 16'h1);

    ifa.en = 1'b1;
    ifa.id_iri = stype(STORE, 3'd4, 3'd2, 4'd3);
    chk_stall("store_r1_hazard", 1'b1);
    step("store_bubble", 16'h0, 16'h0, 16'h0, 16'h0055, 16'h2);

    ifa.id_iri = add123;
    step("pre_reset", add123, 16'h0005, 16'h0007, 16'h0055, 16'h2);
    reset = 1'b1; ifa.flush = 1'b1;
    step("mid_reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b0; ifa.flush = 1'b0;

    for (int k = 0; k < 5; k++) begin
      ifa.id_iri = ld4;
      step("sat_load", ld4, 16'h0005, 16'h0, 16'h0, 16'(k));
      ifa.id_iri = add143;
      chk_stall("sat_hazard", 1'b1);
      step("sat_bubble", 16'h0, 16'h0, 16'h0, 16'h0, 16'(k + 1));
      chk("sat_cnt2", 32'(ifb.bubble_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
